// File: rtl/pc_pkg.sv
// Shared types and default constants for the IF-stage program counter.
// Optional PC_MISALIGN_TRAP_EN build turns misaligned redirect targets into exception redirects.
package pc_pkg;

    typedef enum logic [1:0] {
        PRI_NONE   = 2'd0,
        PRI_JUMP   = 2'd1,
        PRI_BRANCH = 2'd2,
        PRI_EXC    = 2'd3
    } pri_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam int unsigned DEF_PC_WIDTH     = 32;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;
    localparam int unsigned DEF_INCR         = 4;

    function automatic logic outranks(input pri_t a, input pri_t b);
        return a > b;
    endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Redirect/control bus between the pipeline control logic and pc_unit.
// o_misalign exists only when PC_MISALIGN_TRAP_EN is defined.
interface pc_unit_if #(
    parameter int unsigned PC_WIDTH = 32
);
    logic                i_enable;
    logic                i_pc_write;
    logic                i_exc;
    logic                i_branch_taken;
    logic [PC_WIDTH-1:0] i_branch_target;
    logic                i_jump;
    logic [PC_WIDTH-1:0] i_jump_target;
    logic [PC_WIDTH-1:0] o_pc;
    logic [PC_WIDTH-1:0] o_pc_plus;
    logic                o_flush;
    logic                o_redirect_pending;
`ifdef PC_MISALIGN_TRAP_EN
    logic                o_misalign;
`endif

    modport master (
        output i_enable, i_pc_write, i_exc, i_branch_taken, i_branch_target,
               i_jump, i_jump_target,
        input  o_pc, o_pc_plus, o_flush, o_redirect_pending
`ifdef PC_MISALIGN_TRAP_EN
        , input o_misalign
`endif
    );

    modport slave (
        input  i_enable, i_pc_write, i_exc, i_branch_taken, i_branch_target,
               i_jump, i_jump_target,
        output o_pc, o_pc_plus, o_flush, o_redirect_pending
`ifdef PC_MISALIGN_TRAP_EN
        , output o_misalign
`endif
    );

endinterface

// File: rtl/pc_redirect_arb.sv
// Fixed-priority redirect select (exception > branch > jump) with target alignment.
// With PC_MISALIGN_TRAP_EN a misaligned target becomes an exception-level redirect.
module pc_redirect_arb
    import pc_pkg::*;
#(
    parameter int unsigned         PC_WIDTH   = DEF_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0] EXC_VECTOR = PC_WIDTH'(DEF_EXC_VECTOR)
) (
    input  logic                exc,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_target,
    output logic [PC_WIDTH-1:0] target,
    output pri_t                level
`ifdef PC_MISALIGN_TRAP_EN
    , output logic              misalign
`endif
);

    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

    logic [PC_WIDTH-1:0] raw;
    pri_t                raw_level;

    always_comb begin
        raw       = '0;
        raw_level = PRI_NONE;
        if (branch_taken) begin
            raw       = branch_target;
            raw_level = PRI_BRANCH;
        end else if (jump) begin
            raw       = jump_target;
            raw_level = PRI_JUMP;
        end
    end

    always_comb begin
        target = raw & ALIGN_MASK;
        level  = raw_level;
`ifdef PC_MISALIGN_TRAP_EN
        misalign = 1'b0;
        if (raw_level != PRI_NONE && raw[1:0] != 2'b00) begin
            target   = EXC_VECTOR;
            level    = PRI_EXC;
            misalign = ~exc;
        end
`endif
        if (exc) begin
            target = EXC_VECTOR;
            level  = PRI_EXC;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// IF-stage PC register with prioritised redirects, stall buffering of one redirect and a flush pulse.
// Optional PC_MISALIGN_TRAP_EN adds the registered o_misalign pulse.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned         PC_WIDTH     = DEF_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(DEF_RESET_VECTOR),
    parameter logic [PC_WIDTH-1:0] EXC_VECTOR   = PC_WIDTH'(DEF_EXC_VECTOR),
    parameter int unsigned         INCR         = DEF_INCR
) (
    input logic         i_clk,
    input logic         i_reset,
    pc_unit_if.slave    bus
);

    state_t              state;
    logic [PC_WIDTH-1:0] pc;
    logic                flush;
    logic [PC_WIDTH-1:0] pend_target;
    pri_t                pend_level;
    logic [PC_WIDTH-1:0] live_target;
    pri_t                live_level;
    logic                advance;
`ifdef PC_MISALIGN_TRAP_EN
    logic                live_misalign;
    logic                misalign;
`endif

    pc_redirect_arb #(
        .PC_WIDTH   (PC_WIDTH),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_arb (
        .exc           (bus.i_exc),
        .branch_taken  (bus.i_branch_taken),
        .branch_target (bus.i_branch_target),
        .jump          (bus.i_jump),
        .jump_target   (bus.i_jump_target),
        .target        (live_target),
        .level         (live_level)
`ifdef PC_MISALIGN_TRAP_EN
        , .misalign    (live_misalign)
`endif
    );

    assign advance = bus.i_enable & bus.i_pc_write;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state       <= ST_RUN;
            pc          <= RESET_VECTOR;
            flush       <= 1'b0;
            pend_target <= '0;
            pend_level  <= PRI_NONE;
`ifdef PC_MISALIGN_TRAP_EN
            misalign    <= 1'b0;
`endif
        end else begin
            flush <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            misalign <= 1'b0;
`endif
            case (state)
                ST_RUN: begin
                    if (live_level != PRI_NONE) begin
`ifdef PC_MISALIGN_TRAP_EN
                        misalign <= live_misalign;
`endif
                        if (advance) begin
                            pc    <= live_target;
                            flush <= 1'b1;
                        end else begin
                            pend_target <= live_target;
                            pend_level  <= live_level;
                            state       <= ST_HOLD;
                        end
                    end else if (advance) begin
                        pc <= pc + PC_WIDTH'(INCR);
                    end
                end
                ST_HOLD: begin
                    if (advance) begin
                        // On release only an exception-level request may override the buffered target.
                        pc          <= (live_level == PRI_EXC) ? live_target : pend_target;
                        flush       <= 1'b1;
                        pend_target <= '0;
                        pend_level  <= PRI_NONE;
                        state       <= ST_RUN;
`ifdef PC_MISALIGN_TRAP_EN
                        misalign    <= (live_level == PRI_EXC) && live_misalign;
`endif
                    end else if (outranks(live_level, pend_level)) begin
                        pend_target <= live_target;
                        pend_level  <= live_level;
`ifdef PC_MISALIGN_TRAP_EN
                        misalign    <= live_misalign;
`endif
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign bus.o_pc               = pc;
    assign bus.o_pc_plus          = pc + PC_WIDTH'(INCR);
    assign bus.o_flush            = flush;
    assign bus.o_redirect_pending = (state == ST_HOLD);
`ifdef PC_MISALIGN_TRAP_EN
    assign bus.o_misalign         = misalign;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed plan sequences then randomized traffic against a reference model.
// Honours PC_MISALIGN_TRAP_EN when defined.
module tb_pc_unit;

    localparam logic [31:0] EXC = 32'h0000_0080;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc_plus;
        logic        flush;
        logic        pending;
        logic        mis;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_unit_if #(.PC_WIDTH(32)) bus();

    pc_unit #(
        .PC_WIDTH     (32),
        .RESET_VECTOR (32'h0000_0000),
        .EXC_VECTOR   (EXC),
        .INCR         (4)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus.slave)
    );

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    // reference state: program counter plus at most one buffered redirect
    logic [31:0] m_pc = 32'h0;
    bit          m_pend = 1'b0;
    logic [31:0] m_pend_tgt = 32'h0;
    int          m_pend_rank = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit en, input bit pw, input bit exc,
                        input bit br, input logic [31:0] bt, input bit jp, input logic [31:0] jt);
        int          rank;
        logic [31:0] tgt;
        bit          mis;
        exp_t        e;
        @(negedge clk);
        rst_n = ~rst;
        bus.i_enable = en;        bus.i_pc_write = pw;   bus.i_exc = exc;
        bus.i_branch_taken = br;  bus.i_branch_target = bt;
        bus.i_jump = jp;          bus.i_jump_target = jt;

        rank = exc ? 3 : br ? 2 : jp ? 1 : 0;
        tgt  = exc ? EXC : br ? (bt & 32'hFFFF_FFFC) : (jt & 32'hFFFF_FFFC);
        mis  = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        if (!exc && ((br && bt[1:0] != 0) || (!br && jp && jt[1:0] != 0))) begin
            rank = 3; tgt = EXC; mis = 1'b1;
        end
`endif
        e.flush = 1'b0;
        e.mis   = 1'b0;
        if (rst) begin
            m_pc = 32'h0; m_pend = 1'b0;
        end else if (m_pend) begin
            if (en && pw) begin
                m_pc = (rank == 3) ? tgt : m_pend_tgt;
                e.flush = 1'b1; e.mis = (rank == 3) && mis; m_pend = 1'b0;
            end else if (rank > m_pend_rank) begin
                m_pend_tgt = tgt; m_pend_rank = rank; e.mis = mis;
            end
        end else if (rank != 0) begin
            e.mis = mis;
            if (en && pw) begin
                m_pc = tgt; e.flush = 1'b1;
            end else begin
                m_pend = 1'b1; m_pend_tgt = tgt; m_pend_rank = rank;
            end
        end else if (en && pw) begin
            m_pc = m_pc + 32'd4;
        end
        e.pc = m_pc;
        e.pc_plus = m_pc + 32'd4;
        e.pending = m_pend;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        step(0, 1, 1, 0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic stall();
        step(0, 1, 0, 0, 0, 32'h0, 0, 32'h0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pc", bus.o_pc, e.pc);
            chk("pc_plus", bus.o_pc_plus, e.pc_plus);
            chk("flush", 32'(bus.o_flush), 32'(e.flush));
            chk("pending", 32'(bus.o_redirect_pending), 32'(e.pending));
`ifdef PC_MISALIGN_TRAP_EN
            chk("misalign", 32'(bus.o_misalign), 32'(e.mis));
`endif
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_enable = 1'b0; bus.i_pc_write = 1'b0; bus.i_exc = 1'b0;
        bus.i_branch_taken = 1'b0; bus.i_branch_target = '0;
        bus.i_jump = 1'b0; bus.i_jump_target = '0;

        // reset dominates a live jump
        step(1, 1, 1, 0, 0, 32'h0, 1, 32'h200);
        step(1, 1, 1, 0, 0, 32'h0, 1, 32'h200);
        chk("reset_pc", bus.o_pc, 32'h0);
        chk("reset_flush", 32'(bus.o_flush), 32'h0);
        idle(); chk("seq_4", bus.o_pc, 32'h4);
        idle(); chk("seq_8", bus.o_pc, 32'h8);
        idle(); idle(); chk("at_10", bus.o_pc, 32'h10);

        repeat (3) stall();
        chk("stall_pc", bus.o_pc, 32'h10);
        chk("stall_flush", 32'(bus.o_flush), 32'h0);
        step(0, 0, 1, 0, 0, 32'h0, 0, 32'h0);
        chk("disable_pc", bus.o_pc, 32'h10);

        repeat (4) idle();
        chk("at_20", bus.o_pc, 32'h20);
        step(0, 1, 1, 0, 1, 32'h100, 1, 32'h300);
        chk("direct_pc", bus.o_pc, 32'h100);
        chk("direct_flush", 32'(bus.o_flush), 32'h1);
        idle();
        chk("direct_flush_end", 32'(bus.o_flush), 32'h0);

        step(0, 1, 0, 0, 0, 32'h0, 1, 32'h300);
        step(0, 1, 0, 0, 1, 32'h100, 0, 32'h0);
        chk("buf_pending", 32'(bus.o_redirect_pending), 32'h1);
        chk("buf_held", bus.o_pc, 32'h104);
        idle();
        chk("buf_release_pc", bus.o_pc, 32'h100);
        chk("buf_release_flush", 32'(bus.o_flush), 32'h1);
        chk("buf_release_pending", 32'(bus.o_redirect_pending), 32'h0);

        step(0, 1, 0, 0, 1, 32'h100, 0, 32'h0);
        step(0, 1, 1, 1, 0, 32'h0, 0, 32'h0);
        chk("exc_release_pc", bus.o_pc, EXC);
        chk("exc_release_flush", 32'(bus.o_flush), 32'h1);
        idle();

        step(0, 1, 1, 0, 1, 32'h102, 0, 32'h0);
`ifdef PC_MISALIGN_TRAP_EN
        chk("misalign_pc", bus.o_pc, EXC);
        chk("misalign_pulse", 32'(bus.o_misalign), 32'h1);
        idle();
        chk("misalign_end", 32'(bus.o_misalign), 32'h0);
`else
        chk("mask_pc", bus.o_pc, 32'h100);
        idle();
`endif

        step(0, 1, 1, 0, 0, 32'h0, 1, 32'hFFFF_FFFC);
        chk("pre_wrap", bus.o_pc, 32'hFFFF_FFFC);
        idle();
        chk("wrap", bus.o_pc, 32'h0);

        step(0, 1, 0, 0, 0, 32'h0, 1, 32'h300);
        chk("hold_pending", 32'(bus.o_redirect_pending), 32'h1);
        step(1, 1, 0, 0, 0, 32'h0, 0, 32'h0);
        chk("hold_reset_pc", bus.o_pc, 32'h0);
        chk("hold_reset_pending", 32'(bus.o_redirect_pending), 32'h0);
        idle();
        chk("after_reset_pc", bus.o_pc, 32'h4);
        chk("after_reset_flush", 32'(bus.o_flush), 32'h0);

        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 5) == 0, $urandom,
                 $urandom_range(0, 5) == 0, $urandom);
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
